// File: rtl/quadrilatero_pkg.sv
// rtl/quadrilatero_pkg.sv - shared types and sizes for the quadrilatero matrix issue path
// Contents:
//   N_REGS, RD_CNT_W, ID_W, REG_W : scoreboard sizing and instruction id width
//   execution_units_t              : functional unit selector
//   datatype_t                     : element datatype
//   dec_instr_t                    : decoded instruction as produced by the decoder, plus id
package quadrilatero_pkg;

  localparam int N_REGS   = 8;
  localparam int RD_CNT_W = 2;
  localparam int ID_W     = 4;
  localparam int REG_W    = $clog2(N_REGS);

  typedef enum logic [1:0] {
    FU_SA  = 2'd0,
    FU_LSU = 2'd1,
    FU_RF  = 2'd2
  } execution_units_t;

  typedef enum logic [1:0] {
    DT_INT8  = 2'd0,
    DT_INT16 = 2'd1,
    DT_INT32 = 2'd2,
    DT_FP32  = 2'd3
  } datatype_t;

  typedef struct packed {
    logic [ID_W-1:0]       id;
    logic [1:0]            n_matrix_operands_read;
    logic [2:0][REG_W-1:0] rf_read_regs;
    logic [REG_W-1:0]      rf_writeback_reg;
    logic                  rf_writeback;
    logic                  is_store;
    logic                  is_float;
    execution_units_t      exec_unit;
    datatype_t             datatype;
  } dec_instr_t;

endpackage

// File: rtl/quadrilatero_scoreboard.sv
// rtl/quadrilatero_scoreboard.sv - matrix register pending-write bits, reader counters and hazard detect
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   n_rd_i, rd_regs_i      : read operand count and indices of the candidate instruction
//   wb_i, wb_reg_i         : candidate writes back, and to which register
//   issue_i                : candidate is issued this cycle
//   rd_done_i, wb_done_i   : per-register release pulses from the FUs
//   hazard_o               : candidate must not issue (RAW, WAW, WAR or counter saturation)
//   busy_o                 : any pending write or any non-zero reader count
module quadrilatero_scoreboard
  import quadrilatero_pkg::*;
#(
  parameter int N_REGS   = quadrilatero_pkg::N_REGS,
  parameter int RD_CNT_W = quadrilatero_pkg::RD_CNT_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [1:0]            n_rd_i,
  input  logic [2:0][REG_W-1:0] rd_regs_i,
  input  logic                  wb_i,
  input  logic [REG_W-1:0]      wb_reg_i,
  input  logic                  issue_i,
  input  logic [N_REGS-1:0]     rd_done_i,
  input  logic [N_REGS-1:0]     wb_done_i,
  output logic                  hazard_o,
  output logic                  busy_o
);

  // Wide enough to hold counter + up to 3 new readers without wrapping.
  localparam int            SW      = RD_CNT_W + 2;
  localparam logic [SW-1:0] CNT_MAX = SW'((1 << RD_CNT_W) - 1);

  logic [N_REGS-1:0]   r_pending_wr;
  logic [RD_CNT_W-1:0] r_rd_cnt  [N_REGS];
  logic [1:0]          w_occ     [N_REGS];
  logic [RD_CNT_W-1:0] w_cnt_nxt [N_REGS];
  logic                w_raw, w_sat, w_waw, w_war, w_cnt_nz;

  // Readers per register for the candidate; a register named twice counts twice.
  always_comb begin
    for (int r = 0; r < N_REGS; r++) w_occ[r] = '0;
    for (int i = 0; i < 3; i++) begin
      if (i < int'(n_rd_i)) w_occ[rd_regs_i[i]] = w_occ[rd_regs_i[i]] + 2'd1;
    end
  end

  always_comb begin
    w_raw    = 1'b0;
    w_sat    = 1'b0;
    w_cnt_nz = 1'b0;
    for (int r = 0; r < N_REGS; r++) begin
      if (w_occ[r] != 2'd0) begin
        w_raw = w_raw | r_pending_wr[r];
        // Stall if all of this instruction's readers would not fit in the counter.
        w_sat = w_sat | ((SW'(r_rd_cnt[r]) + SW'(w_occ[r])) > CNT_MAX);
      end
      w_cnt_nz = w_cnt_nz | (r_rd_cnt[r] != '0);
      // Net change: new readers in, one release out; a release on zero is dropped.
      w_cnt_nxt[r] = r_rd_cnt[r]
                   + (issue_i ? RD_CNT_W'(w_occ[r]) : '0)
                   - RD_CNT_W'(rd_done_i[r] && (r_rd_cnt[r] != '0));
    end
    w_waw = wb_i && r_pending_wr[wb_reg_i];
    w_war = wb_i && (r_rd_cnt[wb_reg_i] != '0);
  end

  assign hazard_o = w_raw | w_sat | w_waw | w_war;
  assign busy_o   = (|r_pending_wr) | w_cnt_nz;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pending_wr <= '0;
      for (int r = 0; r < N_REGS; r++) r_rd_cnt[r] <= '0;
    end else begin
      // A new write on the register being released keeps it pending.
      r_pending_wr <= (r_pending_wr & ~wb_done_i)
                    | ((issue_i && wb_i) ? (N_REGS'(1) << wb_reg_i) : '0);
      for (int r = 0; r < N_REGS; r++) r_rd_cnt[r] <= w_cnt_nxt[r];
    end
  end

endmodule

// File: rtl/quadrilatero_dispatcher.sv
// rtl/quadrilatero_dispatcher.sv - single-entry buffer that issues decoded matrix instructions in order
// Ports:
//   clk_i, rst_ni                : clock, asynchronous active-low reset
//   instr_valid_i/instr_ready_o  : decoder handshake, instr_i carries the decoded instruction
//   sa_/lsu_/rf_valid_o, _ready_i: issue handshake per functional unit
//   issue_o                      : buffered instruction, shared by all FUs
//   rd_done_i, wb_done_i         : per-register operand-read / writeback completion pulses
//   busy_o                       : buffer full or scoreboard holds any state
module quadrilatero_dispatcher
  import quadrilatero_pkg::*;
#(
  parameter int N_REGS   = quadrilatero_pkg::N_REGS,
  parameter int RD_CNT_W = quadrilatero_pkg::RD_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              instr_valid_i,
  output logic              instr_ready_o,
  input  dec_instr_t        instr_i,
  output logic              sa_valid_o,
  input  logic              sa_ready_i,
  output logic              lsu_valid_o,
  input  logic              lsu_ready_i,
  output logic              rf_valid_o,
  input  logic              rf_ready_i,
  output dec_instr_t        issue_o,
  input  logic [N_REGS-1:0] rd_done_i,
  input  logic [N_REGS-1:0] wb_done_i,
  output logic              busy_o
);

  logic       r_full;
  dec_instr_t r_instr;
  logic       w_hazard, w_sb_busy, w_issue_ok, w_fu_ready, w_fire, w_accept;

  quadrilatero_scoreboard #(
    .N_REGS   (N_REGS),
    .RD_CNT_W (RD_CNT_W)
  ) u_sb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .n_rd_i    (r_instr.n_matrix_operands_read),
    .rd_regs_i (r_instr.rf_read_regs),
    .wb_i      (r_instr.rf_writeback),
    .wb_reg_i  (r_instr.rf_writeback_reg),
    .issue_i   (w_fire),
    .rd_done_i (rd_done_i),
    .wb_done_i (wb_done_i),
    .hazard_o  (w_hazard),
    .busy_o    (w_sb_busy)
  );

  always_comb begin
    w_fu_ready = 1'b0;
    case (r_instr.exec_unit)
      FU_SA:   w_fu_ready = sa_ready_i;
      FU_LSU:  w_fu_ready = lsu_ready_i;
      FU_RF:   w_fu_ready = rf_ready_i;
      default: w_fu_ready = 1'b0;
    endcase
  end

  assign w_issue_ok    = r_full && !w_hazard;
  assign sa_valid_o    = w_issue_ok && (r_instr.exec_unit == FU_SA);
  assign lsu_valid_o   = w_issue_ok && (r_instr.exec_unit == FU_LSU);
  assign rf_valid_o    = w_issue_ok && (r_instr.exec_unit == FU_RF);
  assign w_fire        = w_issue_ok && w_fu_ready;
  // Slot frees up in the same cycle the current entry issues.
  assign instr_ready_o = !r_full || w_fire;
  assign w_accept      = instr_valid_i && instr_ready_o;
  assign issue_o       = r_instr;
  assign busy_o        = r_full || w_sb_busy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_full  <= 1'b0;
      r_instr <= '0;
    end else if (w_accept) begin
      r_full  <= 1'b1;
      r_instr <= instr_i;
    end else if (w_fire) begin
      r_full  <= 1'b0;
    end
  end

endmodule
